// File: rtl/gps_trip_pkg.sv
// Shared types and defaults for the GPS trip statistics block.
package gps_trip_pkg;

    localparam int unsigned DEF_DW = 40;  // segment distance width, Q24.16 metres
    localparam int unsigned DEF_TW = 48;  // trip total width, Q32.16 metres
    localparam int unsigned DEF_CW = 16;  // segment counter width

    // 10000.0 m in Q24.16; segments above this are treated as position glitches
    localparam logic [DEF_DW-1:0] DEF_ALARM_LIMIT = 40'h00_2710_0000;

    // Live minimum starts at all-ones so the first segment always wins
    localparam logic [DEF_DW-1:0] MIN_INIT = '1;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StReport
    } trip_state_e;

endpackage

// File: rtl/gps_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, TW cycles per divide.
// o_done is high during the final iteration cycle; quotient and remainder are
// complete after that clock edge and hold until the next start.
module gps_serial_div
    import gps_trip_pkg::*;
#(
    parameter int unsigned TW = DEF_TW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [TW-1:0] i_dividend,
    input  logic [TW-1:0] i_divisor,
    output logic          o_done,
    output logic [TW-1:0] o_quot,
    output logic [TW-1:0] o_rem
);

    localparam int unsigned CntW = $clog2(TW);

    logic            r_busy;
    logic [CntW-1:0] r_cnt;
    logic [TW-1:0]   r_quot;
    logic [TW-1:0]   r_rem;
    logic [TW-1:0]   r_divisor;

    logic [TW:0]     w_rem_sh;
    logic [TW:0]     w_diff;
    logic            w_fits;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // The remainder stays below the divisor, so a borrow shows up in bit TW.
    assign w_rem_sh = {r_rem, r_quot[TW-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divisor};
    assign w_fits   = ~w_diff[TW];

    assign o_done = r_busy & (r_cnt == CntW'(TW - 1));
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

    // Load operands on start, then retire one quotient bit per cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (r_busy) begin
            r_quot <= {r_quot[TW-2:0], w_fits};
            r_rem  <= w_fits ? w_diff[TW-1:0] : w_rem_sh[TW-1:0];
            r_cnt  <= r_cnt + CntW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gps_trip_accum.sv
// GPS trip statistics accumulator with snapshot report and serial average.
// Optional glitch rejection is compiled in with the GPS_ALARM_EN macro.
module gps_trip_accum
    import gps_trip_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned TW = DEF_TW,
    parameter int unsigned CW = DEF_CW
`ifdef GPS_ALARM_EN
    ,
    parameter logic [DW-1:0] ALARM_LIMIT = DEF_ALARM_LIMIT
`endif
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_seg_valid,
    input  logic [DW-1:0] i_seg_d,
    input  logic          i_clr,
    input  logic          i_rpt_req,
    input  logic          i_rpt_ready,
    output logic          o_rpt_valid,
    output logic [TW-1:0] o_rpt_total,
    output logic [CW-1:0] o_rpt_count,
    output logic [DW-1:0] o_rpt_max,
    output logic [DW-1:0] o_rpt_min,
    output logic [DW-1:0] o_rpt_avg,
    output logic          o_rpt_sat,
    output logic          o_busy,
    output logic          o_seg_alarm
);

    // Live statistics
    logic [TW-1:0] r_total;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_max;
    logic [DW-1:0] r_min;
    logic          r_sat;
    logic          r_seg_valid_q;

    // Snapshot taken at report request
    logic [TW-1:0] r_snap_total;
    logic [CW-1:0] r_snap_count;
    logic [DW-1:0] r_snap_max;
    logic [DW-1:0] r_snap_min;
    logic          r_snap_sat;

    trip_state_e   r_state;
    trip_state_e   w_state_nxt;
    logic          w_snap_load;
    logic          w_div_start;
    logic          w_div_done;
    logic [TW-1:0] w_quot;
    logic [TW-1:0] w_rem;
    logic          w_snap_empty;

    logic          w_seg_accept;
    logic          w_seg_glitch;
    logic          w_seg_take;

    logic [TW-1:0] w_base_total;
    logic [CW-1:0] w_base_count;
    logic [DW-1:0] w_base_max;
    logic [DW-1:0] w_base_min;
    logic          w_base_sat;
    logic [TW:0]   w_sum;
    logic [CW:0]   w_cnt_sum;

    logic [TW-1:0] w_total_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [DW-1:0] w_max_nxt;
    logic [DW-1:0] w_min_nxt;
    logic          w_sat_nxt;

    // Only a rising edge of Valid counts, so a stuck-high strobe adds one segment
    assign w_seg_accept = i_seg_valid & ~r_seg_valid_q;

`ifdef GPS_ALARM_EN
    logic r_seg_alarm;

    assign w_seg_glitch = w_seg_accept & (i_seg_d > ALARM_LIMIT);
    assign o_seg_alarm  = r_seg_alarm;

    // One-cycle alarm pulse following a rejected segment.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_seg_alarm <= 1'b0;
        end else begin
            r_seg_alarm <= w_seg_glitch;
        end
    end
`else
    assign w_seg_glitch = 1'b0;
    assign o_seg_alarm  = 1'b0;
`endif

    assign w_seg_take = w_seg_accept & ~w_seg_glitch;

    // clr is applied before any same-cycle segment, which then opens the new trip
    assign w_base_total = i_clr ? '0 : r_total;
    assign w_base_count = i_clr ? '0 : r_count;
    assign w_base_max   = i_clr ? '0 : r_max;
    assign w_base_min   = i_clr ? MIN_INIT : r_min;
    assign w_base_sat   = i_clr ? 1'b0 : r_sat;

    assign w_sum     = {1'b0, w_base_total} + {{(TW - DW + 1){1'b0}}, i_seg_d};
    assign w_cnt_sum = {1'b0, w_base_count} + {{CW{1'b0}}, 1'b1};

    // Next live statistics: saturating total/count, running max/min.
    always_comb begin
        w_total_nxt = w_base_total;
        w_count_nxt = w_base_count;
        w_max_nxt   = w_base_max;
        w_min_nxt   = w_base_min;
        w_sat_nxt   = w_base_sat;
        if (w_seg_take) begin
            if (w_sum[TW]) begin
                w_total_nxt = '1;
                w_sat_nxt   = 1'b1;
            end else begin
                w_total_nxt = w_sum[TW-1:0];
            end
            if (w_cnt_sum[CW]) begin
                w_count_nxt = '1;
                w_sat_nxt   = 1'b1;
            end else begin
                w_count_nxt = w_cnt_sum[CW-1:0];
            end
            if (i_seg_d > w_base_max) begin
                w_max_nxt = i_seg_d;
            end
            if (i_seg_d < w_base_min) begin
                w_min_nxt = i_seg_d;
            end
        end
    end

    // Live statistics registers and Valid edge detector.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_total       <= '0;
            r_count       <= '0;
            r_max         <= '0;
            r_min         <= MIN_INIT;
            r_sat         <= 1'b0;
            r_seg_valid_q <= 1'b0;
        end else begin
            r_total       <= w_total_nxt;
            r_count       <= w_count_nxt;
            r_max         <= w_max_nxt;
            r_min         <= w_min_nxt;
            r_sat         <= w_sat_nxt;
            r_seg_valid_q <= i_seg_valid;
        end
    end

    // Report FSM next-state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_snap_load = 1'b0;
        w_div_start = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_rpt_req) begin
                    w_snap_load = 1'b1;
                    if (w_count_nxt == '0) begin
                        w_state_nxt = StReport;
                    end else begin
                        w_div_start = 1'b1;
                        w_state_nxt = StDiv;
                    end
                end
            end
            StDiv: begin
                if (w_div_done) begin
                    w_state_nxt = StReport;
                end
            end
            StReport: begin
                if (i_rpt_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Report FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Snapshot capture; includes any segment accepted in the request cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_snap_total <= '0;
            r_snap_count <= '0;
            r_snap_max   <= '0;
            r_snap_min   <= '0;
            r_snap_sat   <= 1'b0;
        end else if (w_snap_load) begin
            r_snap_total <= w_total_nxt;
            r_snap_count <= w_count_nxt;
            r_snap_max   <= w_max_nxt;
            r_snap_min   <= w_min_nxt;
            r_snap_sat   <= w_sat_nxt;
        end
    end

    // Operands come from the same next-state values the snapshot latches
    gps_serial_div #(
        .TW (TW)
    ) u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_div_start),
        .i_dividend (w_total_nxt),
        .i_divisor  ({{(TW - CW){1'b0}}, w_count_nxt}),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Average never exceeds max, so the upper quotient bits are always zero
    logic w_unused;
    assign w_unused = ^{w_quot[TW-1:DW], w_rem};

    assign w_snap_empty = (r_snap_count == '0);

    assign o_rpt_valid = (r_state == StReport);
    assign o_busy      = (r_state != StIdle);
    assign o_rpt_total = r_snap_total;
    assign o_rpt_count = r_snap_count;
    assign o_rpt_max   = r_snap_max;
    assign o_rpt_min   = w_snap_empty ? '0 : r_snap_min;
    assign o_rpt_avg   = w_snap_empty ? '0 : w_quot[DW-1:0];
    assign o_rpt_sat   = r_snap_sat;

endmodule

// File: tb/tb_gps_trip_accum.sv
// Directed bench for gps_trip_accum with hand-computed expectations.
// Define GPS_ALARM_EN for both bench and RTL to exercise glitch rejection.
module tb_gps_trip_accum;

    logic        clk;
    logic        reset;
    logic        seg_valid;
    logic [39:0] seg_d;
    logic        clr;
    logic        rpt_req;
    logic        rpt_ready;
    logic        rpt_valid;
    logic [47:0] rpt_total;
    logic [15:0] rpt_count;
    logic [39:0] rpt_max;
    logic [39:0] rpt_min;
    logic [39:0] rpt_avg;
    logic        rpt_sat;
    logic        busy;
    logic        seg_alarm;

    int n_cmp = 0;
    int n_mis = 0;
    int lat;

    gps_trip_accum dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_seg_valid (seg_valid),
        .i_seg_d     (seg_d),
        .i_clr       (clr),
        .i_rpt_req   (rpt_req),
        .i_rpt_ready (rpt_ready),
        .o_rpt_valid (rpt_valid),
        .o_rpt_total (rpt_total),
        .o_rpt_count (rpt_count),
        .o_rpt_max   (rpt_max),
        .o_rpt_min   (rpt_min),
        .o_rpt_avg   (rpt_avg),
        .o_rpt_sat   (rpt_sat),
        .o_busy      (busy),
        .o_seg_alarm (seg_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_seg(input logic [39:0] d);
        seg_valid = 1'b1;
        seg_d     = d;
        tick();
        seg_valid = 1'b0;
        tick();
    endtask

    // Pulse rpt_req and count cycles until rpt_valid, bounded
    task automatic request(output int cycles);
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
        cycles  = 1;
        while (!rpt_valid && cycles < 80) begin
            tick();
            cycles++;
        end
    endtask

    task automatic accept(input string tag);
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        chk(tag, {63'd0, rpt_valid}, 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        seg_valid = 1'b0;
        seg_d     = '0;
        clr       = 1'b0;
        rpt_req   = 1'b0;
        rpt_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", {63'd0, rpt_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_count", {48'd0, rpt_count}, 64'd0);
        chk("reset_alarm", {63'd0, seg_alarm}, 64'd0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a divide
        send_seg(40'h00_0064_0000);
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
        tick();
        tick();
        chk("div_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #2;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_valid", {63'd0, rpt_valid}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        request(lat);
        chk("empty_latency", 64'(lat), 64'd1);
        chk("empty_count", {48'd0, rpt_count}, 64'd0);
        chk("empty_avg", {24'd0, rpt_avg}, 64'd0);
        chk("empty_min", {24'd0, rpt_min}, 64'd0);
        chk("empty_total", {16'd0, rpt_total}, 64'd0);
        accept("empty_accept");
        chk("empty_idle", {63'd0, busy}, 64'd0);

        // 100 m, 200 m, 300 m
        send_seg(40'h00_0064_0000);
        send_seg(40'h00_00C8_0000);
        send_seg(40'h00_012C_0000);
        request(lat);
        chk("three_latency", 64'(lat), 64'd49);
        chk("three_total", {16'd0, rpt_total}, 64'h0000_0258_0000);
        chk("three_count", {48'd0, rpt_count}, 64'd3);
        chk("three_max", {24'd0, rpt_max}, 64'h00_012C_0000);
        chk("three_min", {24'd0, rpt_min}, 64'h00_0064_0000);
        chk("three_avg", {24'd0, rpt_avg}, 64'h00_00C8_0000);
        chk("three_sat", {63'd0, rpt_sat}, 64'd0);
        accept("three_accept");

        // Valid held for 5 cycles adds a single 1.0 m segment: 601 m / 4 = 150.25 m
        seg_valid = 1'b1;
        seg_d     = 40'h00_0001_0000;
        repeat (5) tick();
        seg_valid = 1'b0;
        tick();
        request(lat);
        chk("held_count", {48'd0, rpt_count}, 64'd4);
        chk("held_total", {16'd0, rpt_total}, 64'h0000_0259_0000);
        chk("held_min", {24'd0, rpt_min}, 64'h00_0001_0000);
        chk("held_avg", {24'd0, rpt_avg}, 64'h00_0096_4000);
        accept("held_accept");

        // clr together with a 50 m segment starts a fresh trip
        clr       = 1'b1;
        seg_valid = 1'b1;
        seg_d     = 40'h00_0032_0000;
        tick();
        clr       = 1'b0;
        seg_valid = 1'b0;
        tick();
        request(lat);
        chk("clr_count", {48'd0, rpt_count}, 64'd1);
        chk("clr_total", {16'd0, rpt_total}, 64'h0000_0032_0000);
        chk("clr_max", {24'd0, rpt_max}, 64'h00_0032_0000);
        chk("clr_min", {24'd0, rpt_min}, 64'h00_0032_0000);
        chk("clr_avg", {24'd0, rpt_avg}, 64'h00_0032_0000);
        accept("clr_accept");

        // 256 maximal segments fall 255 short of full scale
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 256; i++) send_seg(40'hFF_FFFF_FFFF);
        request(lat);
        chk("near_total", {16'd0, rpt_total}, 64'hFFFF_FFFF_FF00);
        chk("near_count", {48'd0, rpt_count}, 64'h100);
        chk("near_sat", {63'd0, rpt_sat}, 64'd0);
        chk("near_avg", {24'd0, rpt_avg}, 64'hFF_FFFF_FFFF);
        accept("near_accept");

        // The 257th saturates; (2^48-1)/257 = 0xFF00FF00FF
        send_seg(40'hFF_FFFF_FFFF);
        request(lat);
        chk("sat_total", {16'd0, rpt_total}, 64'hFFFF_FFFF_FFFF);
        chk("sat_flag", {63'd0, rpt_sat}, 64'd1);
        chk("sat_count", {48'd0, rpt_count}, 64'h101);
        chk("sat_avg", {24'd0, rpt_avg}, 64'hFF_00FF_00FF);

        // Back-pressure: segments and requests while reporting leave fields alone
        seg_valid = 1'b1;
        seg_d     = 40'h00_0001_0000;
        rpt_req   = 1'b1;
        tick();
        seg_valid = 1'b0;
        rpt_req   = 1'b0;
        repeat (9) tick();
        chk("hold_valid", {63'd0, rpt_valid}, 64'd1);
        chk("hold_total", {16'd0, rpt_total}, 64'hFFFF_FFFF_FFFF);
        chk("hold_count", {48'd0, rpt_count}, 64'h101);
        chk("hold_avg", {24'd0, rpt_avg}, 64'hFF_00FF_00FF);
        accept("hold_accept");
        tick();
        chk("no_queue_busy", {63'd0, busy}, 64'd0);

`ifdef GPS_ALARM_EN
        // 20000 m is rejected with an alarm; exactly 10000 m is accepted
        clr = 1'b1;
        tick();
        clr       = 1'b0;
        seg_valid = 1'b1;
        seg_d     = 40'h00_4E20_0000;
        tick();
        seg_valid = 1'b0;
        chk("alarm_pulse", {63'd0, seg_alarm}, 64'd1);
        tick();
        chk("alarm_drop", {63'd0, seg_alarm}, 64'd0);
        seg_valid = 1'b1;
        seg_d     = 40'h00_2710_0000;
        tick();
        seg_valid = 1'b0;
        chk("limit_no_alarm", {63'd0, seg_alarm}, 64'd0);
        tick();
        request(lat);
        chk("alarm_count", {48'd0, rpt_count}, 64'd1);
        chk("alarm_total", {16'd0, rpt_total}, 64'h0000_2710_0000);
        accept("alarm_accept");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gps_trip_accum.md
Name: gps_trip_accum

Overview:
- Downstream consumer of the GPS distance stage.
- Takes each per-segment distance result (valid strobe + 40-bit D, unsigned Q24.16 metres) and accumulates running trip statistics: total, segment count, max, min.
- On host request, produces a snapshot report including the average segment length, computed by a serial divider, over a valid/ready handshake.

Parameters:
- DW, 40, segment distance width (Q24.16).
- TW, 48, total-distance accumulator width (Q32.16).
- CW, 16, segment counter width.
- ALARM_LIMIT, 40'h00_2710_0000, glitch threshold (10000.0 m); used only with GPS_ALARM_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg_valid  in  1  distance-stage Valid.
- seg_d  in  DW  distance-stage D; sampled with seg_valid.
- clr  in  1  one-cycle pulse; zero live statistics.
- rpt_req  in  1  request snapshot report; honoured only in IDLE.
- rpt_ready  in  1  consumer accepts report.
- rpt_valid  out  1  report fields valid; held until accepted.
- rpt_total  out  TW  snapshot total.
- rpt_count  out  CW  snapshot segment count.
- rpt_max  out  DW  snapshot max segment.
- rpt_min  out  DW  snapshot min segment (0 if count = 0).
- rpt_avg  out  DW  total/count, truncated (0 if count = 0).
- rpt_sat  out  1  total or count saturated since last clear.
- busy  out  1  high in DIV and REPORT.
- seg_alarm  out  1  glitch alarm (GPS_ALARM_EN only).

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset (async, any state): all registers and outputs are 0; live min register = all-ones; state = IDLE.
- Segment capture:
  - A segment is accepted when seg_valid = 1 and seg_valid_q = 0 (rising edge; protects against a held Valid).
  - Live registers update at that same edge, so the new values are visible the next cycle.
- Accumulate rules:
  - total += seg_d (zero-extended); saturates at all-ones and sets sat.
  - count += 1; saturates at all-ones and sets sat.
  - max = max(max, seg_d); min = min(min, seg_d).
- Segments are accepted in every state. They update live registers only, never the snapshot.
- clr:
  - Live total, count, max and sat go to 0; min goes to all-ones.
  - If a segment is accepted in the same cycle, clr is applied first and the segment becomes the first of the new trip (count = 1).
- FSM IDLE:
  - On rpt_req, copy live total/count/max/min/sat into the snapshot. The snapshot includes a segment accepted in that same cycle.
  - If count = 0, go to REPORT. Otherwise load the divider and go to DIV.
- FSM DIV:
  - Restoring divider, one quotient bit per cycle, TW cycles.
  - Dividend = snapshot total; divisor = snapshot count zero-extended.
  - Then go to REPORT.
- FSM REPORT:
  - rpt_valid = 1; all rpt_* outputs are stable.
  - On rpt_valid & rpt_ready, go to IDLE; rpt_valid drops the next cycle.
- Report latency:
  - rpt_valid rises TW+1 cycles after the rpt_req edge, or 1 cycle when count = 0.
- Handshake and outputs:
  - rpt_req outside IDLE is ignored (not queued).
  - rpt_* fields are driven from snapshot registers. Only rpt_valid qualifies them.
  - rpt_min is reported as 0 when count = 0.
  - rpt_avg = quotient[DW-1:0]. This is lossless because avg ≤ max < 2^DW.

Optional Feature:
- Macro GPS_ALARM_EN.
- With it defined:
  - An accepted segment with seg_d > ALARM_LIMIT is not accumulated.
  - seg_alarm pulses high for one cycle, the cycle after acceptance.
  - seg_d == ALARM_LIMIT is accumulated normally.
- Without it: every segment is accumulated, and seg_alarm is tied 0.

Decomposition:
- Package gps_trip_pkg holds:
  - state enum (IDLE, DIV, REPORT);
  - DW/TW/CW defaults;
  - ALARM_LIMIT default;
  - MIN_INIT all-ones constant.
- One natural sub-module: gps_serial_div, a TW-bit restoring divider with start/done, and quotient/remainder outputs.

Test Plan:
- Reset mid-DIV, then release → rpt_valid = 0, busy = 0, count = 0; a new rpt_req gives count 0, avg 0, and rpt_valid 1 cycle after the request.
- Segments 40'h00_0064_0000, 00_00C8_0000, 00_012C_0000 (100/200/300 m), then rpt_req → total 48'h0000_0258_0000, count 3, max 300 m, min 100 m, avg 40'h00_00C8_0000; rpt_valid at request+49 cycles.
- seg_valid held high for 5 cycles with seg_d = 1.0 m → count increments by exactly 1.
- clr and a 50 m segment in the same cycle → report shows count 1, total = min = max = 50 m.
- Total preloaded near max via repeated 40'hFF_FFFF_FFFF segments (bench forces counter) → total saturates at all-ones, rpt_sat = 1, no wrap; rpt_ready held low 10 cycles → fields stable, rpt_valid stays high.
- With GPS_ALARM_EN, send a 20000 m segment → seg_alarm pulses once, total unchanged. Then send exactly 10000 m → accumulated, no alarm.
